sdcard_sequencer: RTL and testbench



---
 rtl/sdcard_seq_pkg.sv | 45 ++++
 rtl/sdcard_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_sdcard_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdcard_seq_pkg.sv
// ---------------------------------------------------------------------------
// sdcard_seq_pkg
//
// Shared definitions for the multi-sector SD card transfer sequencer.
//
// Contents:
//   SectorBytes  - bytes per sector. This must equal the buffer size of the
//                  SD card interface block, because the sequencer counts bytes
//                  against the card's own buffer index.
//   ByteIdxWidth - width of a byte index inside one sector.
//   sd_cmd_e     - command codes driven onto sd_command.
//   state_e      - sequencer states.
// ---------------------------------------------------------------------------
package sdcard_seq_pkg;

    // Bytes per sector. Must be a power of two: the byte counter wraps to 0
    // after the last byte of a sector, which matches the card's buffer index.
    localparam int unsigned SectorBytes  = 512;
    localparam int unsigned ByteIdxWidth = $clog2(SectorBytes);

    // Command codes understood by the SD card interface block.
    typedef enum logic [2:0] {
        SdIdle  = 3'd0,  // no operation
        SdRead  = 3'd1,  // load the current sector into the card buffer
        SdNext  = 3'd2,  // advance the buffer index (read side)
        SdPut   = 3'd3,  // store sd_data_in at the buffer index and advance
        SdWrite = 3'd4   // program the card buffer into the current sector
    } sd_cmd_e;

    // Sequencer states.
    typedef enum logic [3:0] {
        WaitInit,    // after reset, wait for the card interface to go idle
        Idle,        // accepting a request
        IssueRead,   // one-cycle SdRead
        IssueWrite,  // one-cycle SdWrite
        StartWait,   // one-cycle guard while the card raises busy
        BusyWait,    // wait for busy low, with timeout
        Stream,      // hand sector bytes to the consumer
        Fill,        // take sector bytes from the producer
        PutDone,     // gap between the last SdPut and SdWrite
        NextSector,  // advance sector / count, finish or loop
        Error        // busy timeout; only reset leaves this state
    } state_e;

endpackage : sdcard_seq_pkg

// File: rtl/sdcard_sequencer.sv
// ---------------------------------------------------------------------------
// sdcard_sequencer
//
// Multi-sector transfer controller sitting between the CPU-side I/O
// peripheral / boot loader and the SD card interface block. It accepts one
// request (direction, start sector, sector count) and walks it sector by
// sector:
//   read : SdRead -> wait busy -> stream SectorBytes bytes to the consumer
//   write: take SectorBytes bytes from the producer -> SdWrite -> wait busy
// Bytes move one per cycle when neither side stalls. A card that stays busy
// for BusyTimeout cycles drops the sequencer into a sticky error state.
//
// Parameters:
//   CountWidth  - width of req_count
//   BusyTimeout - maximum cycles sd_busy may stay high per operation
//   (SectorBytes comes from sdcard_seq_pkg so the card interface and this
//    block share a single definition.)
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req_valid/req_ready request handshake (req_ready high only in Idle)
//   req_write           1 = write sectors, 0 = read sectors
//   req_sector          first sector of the transfer
//   req_count           number of sectors (0 completes immediately)
//   rd_valid/rd_ready   read byte stream towards the consumer
//   rd_data             read byte (card buffer byte at the current index)
//   wr_valid/wr_ready   write byte stream from the producer
//   wr_data             byte to write
//   done                one-cycle pulse at the end of a request
//   err                 sticky busy-timeout flag
//   sd_command          command to the card interface (see sd_cmd_e)
//   sd_sector           current sector
//   sd_data_in          byte to store in the card buffer
//   sd_data_out         card buffer byte at the current index
//   sd_busy             card interface busy
// ---------------------------------------------------------------------------
module sdcard_sequencer
    import sdcard_seq_pkg::*;
#(
    parameter int unsigned CountWidth  = 16,
    parameter int unsigned BusyTimeout = 16777216
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_sector,
    input  logic [CountWidth-1:0] req_count,

    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [7:0]            rd_data,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [7:0]            wr_data,

    output logic                  done,
    output logic                  err,

    output logic [2:0]            sd_command,
    output logic [31:0]           sd_sector,
    output logic [7:0]            sd_data_in,
    input  logic [7:0]            sd_data_out,
    input  logic                  sd_busy
);

    // The timeout counter only has to reach BusyTimeout-1.
    localparam int unsigned TimeoutWidth =
        ($clog2(BusyTimeout) < 1) ? 1 : $clog2(BusyTimeout);
    localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(BusyTimeout - 1);
    localparam logic [ByteIdxWidth-1:0] ByteLast    = ByteIdxWidth'(SectorBytes - 1);
    localparam logic [CountWidth-1:0]   CountOne    = CountWidth'(1);

    state_e                  state;
    state_e                  state_next;

    logic [31:0]             sector;       // current sector
    logic [CountWidth-1:0]   count_left;   // sectors still to transfer
    logic                    dir_write;    // latched request direction
    logic [ByteIdxWidth-1:0] byte_cnt;     // byte index inside the sector
    logic [TimeoutWidth-1:0] timeout_cnt;  // busy cycles in this operation
    logic                    zero_done;    // a zero-count request was accepted

    sd_cmd_e                 cmd;
    logic                    byte_last;
    logic                    accept;

    assign byte_last  = (byte_cnt == ByteLast);
    assign accept     = (state == Idle) && req_valid;
    assign sd_command = cmd;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential logic uses non-blocking assignments so every register
    // samples the values of the previous cycle regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WaitInit;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            WaitInit: begin
                if (!sd_busy) state_next = Idle;
            end
            Idle: begin
                // A zero-count request is acknowledged from Idle itself.
                if (req_valid && (req_count != '0)) begin
                    state_next = req_write ? Fill : IssueRead;
                end
            end
            IssueRead:  state_next = StartWait;
            IssueWrite: state_next = StartWait;
            StartWait:  state_next = BusyWait;
            BusyWait: begin
                if (!sd_busy) begin
                    state_next = dir_write ? NextSector : Stream;
                end else if (timeout_cnt == TimeoutLast) begin
                    state_next = Error;
                end
            end
            Stream: begin
                // rd_valid is always high here, so rd_ready is the handshake.
                if (rd_ready && byte_last) state_next = NextSector;
            end
            Fill: begin
                if (wr_valid && byte_last) state_next = PutDone;
            end
            // Keeps SdWrite from directly following the last SdPut.
            PutDone:    state_next = IssueWrite;
            NextSector: begin
                if (count_left == CountOne) begin
                    state_next = Idle;
                end else begin
                    state_next = dir_write ? Fill : IssueRead;
                end
            end
            Error:      state_next = Error;
            default:    state_next = WaitInit;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: request latch, byte counter, timeout counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sector      <= '0;
            count_left  <= '0;
            dir_write   <= 1'b0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            zero_done   <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                Idle: begin
                    if (accept) begin
                        sector     <= req_sector;
                        count_left <= req_count;
                        dir_write  <= req_write;
                        zero_done  <= (req_count == '0);
                    end
                end
                StartWait: timeout_cnt <= '0;
                BusyWait:  timeout_cnt <= timeout_cnt + 1'b1;
                // The byte counter wraps to 0 after the last byte, in step
                // with the card's buffer index.
                Stream: begin
                    if (rd_ready) byte_cnt <= byte_cnt + 1'b1;
                end
                Fill: begin
                    if (wr_valid) byte_cnt <= byte_cnt + 1'b1;
                end
                NextSector: begin
                    sector     <= sector + 32'd1;
                    count_left <= count_left - CountOne;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output logic
    // -----------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        req_ready  = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = 8'h00;
        wr_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cmd        = SdIdle;
        sd_sector  = sector;
        sd_data_in = 8'h00;
        case (state)
            Idle: begin
                req_ready = 1'b1;
                done      = zero_done;
            end
            IssueRead:  cmd = SdRead;
            IssueWrite: cmd = SdWrite;
            Stream: begin
                rd_valid = 1'b1;
                rd_data  = sd_data_out;
                // Advancing the index in the handshake cycle puts the next
                // byte on sd_data_out in the following cycle: no bubble.
                if (rd_ready) cmd = SdNext;
            end
            Fill: begin
                wr_ready   = 1'b1;
                sd_data_in = wr_data;
                if (wr_valid) cmd = SdPut;
            end
            NextSector: begin
                done = (count_left == CountOne);
            end
            Error: begin
                err       = 1'b1;
                sd_sector = 32'd0;
            end
            default: ;
        endcase
    end

endmodule : sdcard_sequencer

// File: tb/tb_sdcard_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sdcard_sequencer
//
// Self-checking bench for sdcard_sequencer. A behavioural card interface
// (busy for a fixed number of cycles after each read/write, read buffer
// filled with sector[7:0] ^ index) surrounds the DUT. Expected read bytes,
// command counts, sectors and written images are derived directly from the
// transfer rules: byte k of a read starting at sector s is
// (s + k / SectorBytes)[7:0] ^ (k % SectorBytes)[7:0].
// ---------------------------------------------------------------------------
module tb_sdcard_sequencer;
    import sdcard_seq_pkg::*;

    localparam int CW       = 16;
    localparam int TO       = 100;  // busy timeout used for this bench
    localparam int BUSY_CYC = 50;   // card busy time after read/write
    localparam int INIT_CYC = 8;    // card busy time after reset

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [31:0]   req_sector;
    logic [CW-1:0] req_count;
    logic          rd_valid;
    logic          rd_ready;
    logic [7:0]    rd_data;
    logic          wr_valid;
    logic          wr_ready;
    logic [7:0]    wr_data;
    logic          done;
    logic          err;
    logic [2:0]    sd_command;
    logic [31:0]   sd_sector;
    logic [7:0]    sd_data_in;
    logic [7:0]    sd_data_out;
    logic          sd_busy;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sdcard_sequencer #(
        .CountWidth (CW),
        .BusyTimeout(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_sector (req_sector),
        .req_count  (req_count),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .done       (done),
        .err        (err),
        .sd_command (sd_command),
        .sd_sector  (sd_sector),
        .sd_data_in (sd_data_in),
        .sd_data_out(sd_data_out),
        .sd_busy    (sd_busy)
    );

    // ------------------------------------------------------------------
    // Behavioural card interface
    // ------------------------------------------------------------------
    logic [7:0]              card_buf [0:SectorBytes-1];
    logic [ByteIdxWidth-1:0] card_idx;
    int                      card_busy_cnt;
    logic                    stuck_busy;
    logic [31:0]             wr_sec [0:15];
    logic [7:0]              wr_img [0:15][0:SectorBytes-1];
    int                      wr_n;

    assign sd_busy     = stuck_busy || (card_busy_cnt != 0);
    assign sd_data_out = card_buf[card_idx];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            card_idx      <= '0;
            card_busy_cnt <= INIT_CYC;
            wr_n          <= 0;
        end else begin
            if (card_busy_cnt != 0) card_busy_cnt <= card_busy_cnt - 1;
            case (sd_command)
                3'd1: begin
                    for (int i = 0; i < SectorBytes; i++)
                        card_buf[i] <= sd_sector[7:0] ^ 8'(i);
                    card_idx      <= '0;
                    card_busy_cnt <= BUSY_CYC;
                end
                3'd2: card_idx <= card_idx + 1'b1;
                3'd3: begin
                    card_buf[card_idx] <= sd_data_in;
                    card_idx           <= card_idx + 1'b1;
                end
                3'd4: begin
                    if (wr_n < 16) begin
                        wr_sec[wr_n] <= sd_sector;
                        for (int i = 0; i < SectorBytes; i++)
                            wr_img[wr_n][i] <= card_buf[i];
                    end
                    wr_n          <= wr_n + 1;
                    card_idx      <= '0;
                    card_busy_cnt <= BUSY_CYC;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to a cycle where req_ready is high (bounded).
    task automatic wait_idle(input string tag);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            #1;
            if (req_ready) found = 1'b1;
        end
        check({tag, " idle_reached"}, 64'(found), 64'd1);
    endtask

    // Present a request in an Idle cycle; it is accepted at the next edge.
    task automatic issue(input string tag, input logic wr, input logic [31:0] sec,
                         input int cnt);
        wait_idle(tag);
        req_valid  = 1'b1;
        req_write  = wr;
        req_sector = sec;
        req_count  = CW'(cnt);
    endtask

    // Command-sequencing rule: two non-zero commands may only be adjacent
    // as a run of SdNext or a run of SdPut.
    function automatic bit seq_bad(input logic [2:0] prev, input logic [2:0] cur);
        return (prev != 3'd0) && (cur != 3'd0) &&
               !((prev == cur) && ((cur == 3'd2) || (cur == 3'd3)));
    endfunction

    // mode: 0 rd_ready always 1, 1 toggling, 2 random.
    // abort_at >= 0 returns as soon as that many bytes were taken.
    task automatic run_read(input string tag, input logic [31:0] sec, input int cnt,
                            input int mode, input int abort_at,
                            output logic [7:0] got0, output logic [7:0] got512);
        int          k, n_rd_cmd, n_done, n_bad_data, n_bad_hs, n_seq, n_bad_sec, n_valid;
        logic [31:0] s;
        logic [7:0]  exp_b;
        logic [2:0]  prev_cmd;
        k = 0; n_rd_cmd = 0; n_done = 0; n_bad_data = 0; n_bad_hs = 0;
        n_seq = 0; n_bad_sec = 0; n_valid = 0;
        got0 = 8'hxx; got512 = 8'hxx;
        prev_cmd = 3'd0;
        issue(tag, 1'b0, sec, cnt);
        for (int cyc = 0; cyc < cnt * (3 * SectorBytes + BUSY_CYC + 20) + 50 && n_done == 0; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (sd_command == 3'd1) begin
                if (sd_sector !== sec + 32'(n_rd_cmd)) n_bad_sec++;
                n_rd_cmd++;
            end
            if (rd_valid) n_valid++;
            if (rd_valid && rd_ready) begin
                s     = sec + 32'(k / SectorBytes);
                exp_b = s[7:0] ^ 8'(k % SectorBytes);
                if (rd_data !== exp_b) n_bad_data++;
                if (k == 0) got0 = rd_data;
                if (k == SectorBytes) got512 = rd_data;
                k++;
                if (sd_command != 3'd2) n_bad_hs++;
            end else if (sd_command == 3'd2) begin
                n_bad_hs++;
            end
            if (rd_valid && wr_ready) n_bad_hs++;
            if (seq_bad(prev_cmd, sd_command)) n_seq++;
            prev_cmd = sd_command;
            if (done) n_done++;
            if (abort_at >= 0 && k == abort_at) return;
        end
        check({tag, " bytes"},      64'(k),          64'(cnt * SectorBytes));
        check({tag, " data_bad"},   64'(n_bad_data), 64'd0);
        check({tag, " read_cmds"},  64'(n_rd_cmd),   64'(cnt));
        check({tag, " sector_bad"}, 64'(n_bad_sec),  64'd0);
        check({tag, " handshake"},  64'(n_bad_hs),   64'd0);
        check({tag, " cmd_seq"},    64'(n_seq),      64'd0);
        check({tag, " done"},       64'(n_done),     64'd1);
        if (mode == 0) check({tag, " full_rate"}, 64'(n_valid), 64'(k));
        @(negedge clk);
        #1;
        check({tag, " done_once"}, 64'(done),      64'd0);
        check({tag, " idle_after"}, 64'(req_ready), 64'd1);
    endtask

    // mode: 0 wr_valid always 1, otherwise random.
    task automatic run_write(input string tag, input logic [31:0] sec, input int cnt,
                             input int mode);
        int base, p, puts, n_wr_cmd, n_done, n_bad_hs, n_bad_cnt, n_seq, n_bad_sec, n_bad_img;
        logic [2:0] prev_cmd;
        base = wr_n;
        p = 0; puts = 0; n_wr_cmd = 0; n_done = 0; n_bad_hs = 0;
        n_bad_cnt = 0; n_seq = 0; n_bad_sec = 0; n_bad_img = 0;
        prev_cmd = 3'd0;
        issue(tag, 1'b1, sec, cnt);
        for (int cyc = 0; cyc < cnt * (3 * SectorBytes + BUSY_CYC + 20) + 50 && n_done == 0; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            wr_valid  = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wr_data   = 8'(p % SectorBytes);
            #1;
            if (wr_valid && wr_ready) begin
                if (sd_command != 3'd3 || sd_data_in !== wr_data) n_bad_hs++;
                p++;
                puts++;
            end else if (sd_command == 3'd3) begin
                n_bad_hs++;
            end
            if (sd_command == 3'd4) begin
                if (puts != SectorBytes) n_bad_cnt++;
                if (sd_sector !== sec + 32'(n_wr_cmd)) n_bad_sec++;
                puts = 0;
                n_wr_cmd++;
            end
            if (rd_valid && wr_ready) n_bad_hs++;
            if (seq_bad(prev_cmd, sd_command)) n_seq++;
            prev_cmd = sd_command;
            if (done) n_done++;
        end
        wr_valid = 1'b0;
        check({tag, " bytes"},      64'(p),         64'(cnt * SectorBytes));
        check({tag, " write_cmds"}, 64'(n_wr_cmd),  64'(cnt));
        check({tag, " puts_per"},   64'(n_bad_cnt), 64'd0);
        check({tag, " sector_bad"}, 64'(n_bad_sec), 64'd0);
        check({tag, " handshake"},  64'(n_bad_hs),  64'd0);
        check({tag, " cmd_seq"},    64'(n_seq),     64'd0);
        check({tag, " done"},       64'(n_done),    64'd1);
        for (int n = 0; n < cnt && base + n < 16; n++) begin
            if (wr_sec[base + n] !== sec + 32'(n)) n_bad_img++;
            for (int j = 0; j < SectorBytes; j++)
                if (wr_img[base + n][j] !== 8'(j)) n_bad_img++;
        end
        check({tag, " card_image"}, 64'(n_bad_img), 64'd0);
        @(negedge clk);
        #1;
        check({tag, " done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=hang expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic [7:0]  g0, g512;
        logic [31:0] sec;
        int          cnt, c1, ce, n_loud;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_sector = '0; req_count = '0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = '0; stuck_busy = 1'b0;

        // Reset state and WaitInit.
        #1;
        check("rst req_ready",  64'(req_ready),  64'd0);
        check("rst sd_command", 64'(sd_command), 64'd0);
        check("rst streams",    64'({rd_valid, wr_ready, done, err}), 64'd0);
        check("rst sd_sector",  64'(sd_sector),  64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("waitinit req_ready", 64'(req_ready), 64'd0);

        // Two-sector read at full rate.
        run_read("rd_full", 32'd5, 2, 0, -1, g0, g512);
        check("rd_full byte0",   64'(g0),   64'h05);
        check("rd_full byte512", 64'(g512), 64'h06);

        // Read with a toggling consumer.
        run_read("rd_toggle", $urandom, 1, 1, -1, g0, g512);

        // Write across the 32-bit sector wrap.
        run_write("wr_wrap", 32'hFFFF_FFFF, 2, 0);

        // Zero-count request.
        issue("zero", 1'($urandom_range(0, 1)), $urandom, 0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("zero done",      64'(done),       64'd1);
        check("zero req_ready", 64'(req_ready),  64'd1);
        check("zero cmd",       64'(sd_command), 64'd0);
        @(negedge clk);
        #1;
        check("zero done_once", 64'(done),       64'd0);

        // Random transfers with random stalls.
        for (int t = 0; t < 3; t++) begin
            sec = $urandom;
            cnt = $urandom_range(1, 2);
            if ($urandom_range(0, 1) == 1) run_write($sformatf("rnd%0d_wr", t), sec, cnt, 2);
            else                          run_read($sformatf("rnd%0d_rd", t), sec, cnt, 2, -1, g0, g512);
        end

        // Reset in the middle of streaming.
        run_read("abort", 32'h0000_0033, 2, 0, 200, g0, g512);
        #1;
        rst = 1'b1;
        #1;
        check("abort rst cmd",       64'(sd_command), 64'd0);
        check("abort rst streams",   64'({rd_valid, wr_ready, done, err}), 64'd0);
        check("abort rst rd_data",   64'(rd_data),    64'd0);
        check("abort rst req_ready", 64'(req_ready),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort waitinit", 64'(req_ready), 64'd0);
        run_read("after_abort", 32'd77, 1, 2, -1, g0, g512);
        check("after_abort byte0", 64'(g0), 64'(8'd77));

        // Busy stuck high: error after BusyTimeout busy cycles. From the
        // SdRead cycle: one StartWait cycle, TO BusyWait cycles, then Error.
        stuck_busy = 1'b1;
        issue("timeout", 1'b0, $urandom, 1);
        c1 = -1;
        ce = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            #1;
            if (sd_command == 3'd1 && c1 < 0) c1 = cyc;
            if (err) begin
                ce = cyc;
                break;
            end
        end
        check("timeout latency", 64'(ce - c1), 64'(TO + 2));
        n_loud = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_count = CW'(1);
            #1;
            if (req_ready || rd_valid || wr_ready || done || sd_command != 3'd0 || !err)
                n_loud++;
        end
        check("error quiet", 64'(n_loud), 64'd0);
        req_valid  = 1'b0;
        rst        = 1'b1;
        stuck_busy = 1'b0;
        #1;
        check("error cleared", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("recover");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sdcard_sequencer
